spi_pp_rx: RTL

SPI_PP_RX -- requirements
Module: spi_pp_rx

---
 rtl/spi_pp_pkg.sv | 21 ++
 rtl/spi_sync2.sv | 29 ++
 rtl/spi_pp_rx.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_pp_pkg.sv
// rtl/spi_pp_pkg.sv - shared constants and types for the SPI ping-pong receiver
//
// Purpose: byte width, bank count, default bank depth and the bank FSM state
//          type used by spi_pp_rx.
// Ports:   none (package).

package spi_pp_pkg;

   localparam int BYTE_W        = 8;
   localparam int NUM_BANKS     = 2;
   localparam int DEFAULT_DEPTH = 256;
   localparam int BIT_CNT_W     = $clog2(BYTE_W);

   // ST_FILL: bytes are written into cur_bank.
   // ST_WAIT_FREE: both banks are owned by the reader; completed bytes are dropped.
   typedef enum logic {
      ST_FILL      = 1'b0,
      ST_WAIT_FREE = 1'b1
   } bank_state_t;

endpackage

// File: rtl/spi_sync2.sv
// rtl/spi_sync2.sv - two-flop synchronizer for one asynchronous input bit
//
// Purpose: brings an asynchronous level into the clk domain.
// Ports:
//   clk   in   system clock
//   rst_n in   asynchronous active-low reset, clears both stages
//   d     in   asynchronous input
//   q     out  synchronized output (stage 2)

module spi_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/spi_pp_rx.sv
// rtl/spi_pp_rx.sv - SPI mode-0 slave receiver writing bytes into ping-pong RAM banks
//
// Purpose: deserializes MOSI bytes (MSB first) and writes them into one of two
//          RAM banks of DEPTH bytes. A full bank is handed to the reader with a
//          bank_ready pulse; the reader gives it back with rd_done. When both
//          banks are owned by the reader, completed bytes are dropped and the
//          sticky overflow flag is set.
// Configuration: define SPI_RX_PARTIAL_FLUSH_EN to also hand over a partially
//          filled bank when chip select is released.
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   sck        in   SPI clock (async), sampled on its rising edge
//   cs_n       in   SPI chip select (async), active low
//   mosi       in   SPI data (async), MSB first
//   wr_en      out  one-cycle RAM write strobe
//   wr_addr    out  {bank, byte index}
//   wr_data    out  received byte
//   bank_ready out  one-cycle pulse, bank handed to reader
//   ready_bank out  bank index qualified by bank_ready
//   ready_len  out  byte count qualified by bank_ready (1..DEPTH)
//   rd_done    in   one-cycle pulse, reader releases rd_bank
//   rd_bank    in   bank index qualified by rd_done
//   overflow   out  sticky, a byte was dropped for lack of a free bank

module spi_pp_rx
   import spi_pp_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          sck,
   input  logic          cs_n,
   input  logic          mosi,
   output logic          wr_en,
   output logic [AW:0]   wr_addr,
   output logic [7:0]    wr_data,
   output logic          bank_ready,
   output logic          ready_bank,
   output logic [AW:0]   ready_len,
   input  logic          rd_done,
   input  logic          rd_bank,
   output logic          overflow
);

   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   // ---------------------------------------------------------------
   // Synchronizers
   // ---------------------------------------------------------------
   logic sck_s, cs_s, mosi_s;

   spi_sync2 u_sync_sck  (.clk(clk), .rst_n(rst_n), .d(sck),  .q(sck_s));
   spi_sync2 u_sync_cs   (.clk(clk), .rst_n(rst_n), .d(cs_n), .q(cs_s));
   spi_sync2 u_sync_mosi (.clk(clk), .rst_n(rst_n), .d(mosi), .q(mosi_s));

   // ---------------------------------------------------------------
   // Bit capture and byte assembly
   // ---------------------------------------------------------------
   // The edge, its data bit and the chip-select level are registered together
   // so they stay aligned: all three travelled through identical synchronizers.
   logic                  sck_d;
   logic                  rise_q;
   logic                  bit_q;
   logic                  cs_low_q;
   logic [BYTE_W-2:0]     shift;
   logic [BIT_CNT_W-1:0]  bit_cnt;
   logic                  byte_valid;
   logic [BYTE_W-1:0]     byte_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sck_d      <= 1'b0;
         rise_q     <= 1'b0;
         bit_q      <= 1'b0;
         cs_low_q   <= 1'b0;
         shift      <= '0;
         bit_cnt    <= '0;
         byte_valid <= 1'b0;
         byte_q     <= '0;
      end else begin
         sck_d      <= sck_s;
         rise_q     <= sck_s & ~sck_d;
         bit_q      <= mosi_s;
         cs_low_q   <= ~cs_s;
         byte_valid <= 1'b0;
         if (rise_q && cs_low_q) begin
            shift   <= {shift[BYTE_W-3:0], bit_q};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BIT_CNT_W'(BYTE_W - 1)) begin
               byte_valid <= 1'b1;
               byte_q     <= {shift, bit_q};
            end
         end else if (!cs_low_q) begin
            // deselected: any partial byte is abandoned
            shift   <= '0;
            bit_cnt <= '0;
         end
      end
   end

   // ---------------------------------------------------------------
   // Chip-select release request (partial flush)
   // ---------------------------------------------------------------
   logic flush;

`ifdef SPI_RX_PARTIAL_FLUSH_EN
   logic cs_d;
   logic cs_rise_q;
   logic flush_q;

   // Two register stages so the request lines up with byte_valid; a byte that
   // completes together with deselect is then written before the flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cs_d      <= 1'b0;
         cs_rise_q <= 1'b0;
         flush_q   <= 1'b0;
      end else begin
         cs_d      <= cs_s;
         cs_rise_q <= cs_s & ~cs_d;
         flush_q   <= cs_rise_q;
      end
   end

   assign flush = flush_q;
`else
   assign flush = 1'b0;
`endif

   // ---------------------------------------------------------------
   // Bank FSM
   // ---------------------------------------------------------------
   bank_state_t            state, nxt_state;
   logic [AW:0]            fill, nxt_fill, fill_inc;
   logic                   cur_bank, nxt_cur;
   logic [NUM_BANKS-1:0]   owned, nxt_owned;
   logic                   nxt_overflow;
   logic                   nxt_wr_en;
   logic [AW:0]            nxt_wr_addr;
   logic [7:0]             nxt_wr_data;
   logic                   nxt_bank_ready;
   logic                   nxt_ready_bank;
   logic [AW:0]            nxt_ready_len;
   logic                   other_bank;

   assign other_bank = ~cur_bank;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_FILL;
         fill       <= '0;
         cur_bank   <= 1'b0;
         owned      <= '0;
         overflow   <= 1'b0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         bank_ready <= 1'b0;
         ready_bank <= 1'b0;
         ready_len  <= '0;
      end else begin
         state      <= nxt_state;
         fill       <= nxt_fill;
         cur_bank   <= nxt_cur;
         owned      <= nxt_owned;
         overflow   <= nxt_overflow;
         wr_en      <= nxt_wr_en;
         wr_addr    <= nxt_wr_addr;
         wr_data    <= nxt_wr_data;
         bank_ready <= nxt_bank_ready;
         ready_bank <= nxt_ready_bank;
         ready_len  <= nxt_ready_len;
      end
   end

   always_comb begin
      nxt_state      = state;
      nxt_fill       = fill;
      nxt_cur        = cur_bank;
      nxt_owned      = owned;
      nxt_overflow   = overflow;
      nxt_wr_en      = 1'b0;
      nxt_wr_addr    = wr_addr;
      nxt_wr_data    = wr_data;
      nxt_bank_ready = 1'b0;
      nxt_ready_bank = ready_bank;
      nxt_ready_len  = ready_len;
      fill_inc       = fill;

      // Release is applied first so a bank freed in the same cycle as a
      // handover is already seen as free when choosing the next state.
      if (rd_done && owned[rd_bank]) begin
         nxt_owned[rd_bank] = 1'b0;
      end

      case (state)
         ST_FILL: begin
            if (byte_valid) begin
               nxt_wr_en   = 1'b1;
               nxt_wr_addr = {cur_bank, fill[AW-1:0]};
               nxt_wr_data = byte_q;
               fill_inc    = fill + 1'b1;
            end
            if ((fill_inc == FULL) || (flush && (fill_inc != '0))) begin
               nxt_bank_ready      = 1'b1;
               nxt_ready_bank      = cur_bank;
               nxt_ready_len       = fill_inc;
               nxt_owned[cur_bank] = 1'b1;
               nxt_fill            = '0;
               nxt_cur             = other_bank;
               nxt_state           = nxt_owned[other_bank] ? ST_WAIT_FREE : ST_FILL;
            end else begin
               nxt_fill = fill_inc;
            end
         end
         ST_WAIT_FREE: begin
            if (byte_valid) begin
               nxt_overflow = 1'b1;
            end
            // cur_bank already points at the bank being waited for
            if (rd_done && owned[rd_bank] && (rd_bank == cur_bank)) begin
               nxt_state = ST_FILL;
               nxt_fill  = '0;
            end
         end
         default: nxt_state = ST_FILL;
      endcase
   end

endmodule
